// File: rtl/wbs_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: state encoding (equal to gnt_o),
// watchdog constants and the per-master request bundle.
package wbs_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } arb_state_e;

    localparam int TO_CYCLES_DEF = 16;
    localparam int WDT_CNT_W     = 8;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
        logic        cyc;
        logic        stb;
    } wb_req_t;

    // Fresh arbitration from idle; last=1 means m1 held the bus most recently.
    function automatic arb_state_e arb_pick(input logic cyc0, input logic cyc1, input logic last);
        if (cyc0 && cyc1) return last ? ST_GNT0 : ST_GNT1;
        if (cyc0)         return ST_GNT0;
        if (cyc1)         return ST_GNT1;
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/wbs_arb_wdt.sv
// Strobe watchdog: counts stalled strobe cycles and flags a timeout on the
// TO_CYCLES-th one. Only built when WBS_ARB_TIMEOUT_EN is defined.
module wbs_arb_wdt
    import wbs_arb_pkg::*;
#(
    parameter int TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_stall,
    input  logic i_clr,
    output logic o_timeout
);

    localparam logic [WDT_CNT_W-1:0] LIMIT = WDT_CNT_W'(TO_CYCLES - 1);

    logic [WDT_CNT_W-1:0] r_cnt;

    assign o_timeout = i_stall & (r_cnt == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (!i_stall || i_clr || o_timeout)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + WDT_CNT_W'(1);
    end

endmodule

// File: rtl/wbs_arb2.sv
// Two-master Wishbone arbiter in front of wbs_mem: cyc-locked grants, round-robin
// tie-break, optional strobe watchdog under WBS_ARB_TIMEOUT_EN.
module wbs_arb2
    import wbs_arb_pkg::*;
#(
    parameter int TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,
    output logic [1:0]  gnt_o
);

    if (TO_CYCLES < 2 || TO_CYCLES > 255) begin : g_bad_to
        $error("wbs_arb2: TO_CYCLES must be in 2..255");
    end

    arb_state_e r_state, w_state_nxt;
    logic       r_last;
    wb_req_t    w_m0, w_m1, w_req;
    logic       w_gnt0, w_gnt1;
    logic       w_to;

    assign w_m0 = '{adr: m0_adr_i, dat: m0_dat_i, we: m0_we_i, sel: m0_sel_i,
                    cyc: m0_cyc_i, stb: m0_stb_i};
    assign w_m1 = '{adr: m1_adr_i, dat: m1_dat_i, we: m1_we_i, sel: m1_sel_i,
                    cyc: m1_cyc_i, stb: m1_stb_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == ST_GNT0) r_last <= 1'b0;
            if (w_state_nxt == ST_GNT1) r_last <= 1'b1;
        end
    end

    // A grant is held for the whole cyc; on release the waiting master takes over directly.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_GNT0: w_state_nxt = m0_cyc_i ? ST_GNT0 : (m1_cyc_i ? ST_GNT1 : ST_IDLE);
            ST_GNT1: w_state_nxt = m1_cyc_i ? ST_GNT1 : (m0_cyc_i ? ST_GNT0 : ST_IDLE);
            default: w_state_nxt = arb_pick(m0_cyc_i, m1_cyc_i, r_last);
        endcase
    end

    always_comb begin
        w_req  = '0;
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            ST_GNT0: begin
                w_req  = w_m0;
                w_gnt0 = 1'b1;
            end
            ST_GNT1: begin
                w_req  = w_m1;
                w_gnt1 = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef WBS_ARB_TIMEOUT_EN
    logic w_stall, w_clr;

    assign w_stall = w_req.cyc & w_req.stb & ~(s_ack_i | s_err_i | s_rty_i);
    assign w_clr   = (w_state_nxt != r_state);

    wbs_arb_wdt #(.TO_CYCLES(TO_CYCLES)) u_wdt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_stall   (w_stall),
        .i_clr     (w_clr),
        .o_timeout (w_to)
    );
`else
    assign w_to = 1'b0;
`endif

    assign s_adr_o  = w_req.adr;
    assign s_dat_o  = w_req.dat;
    assign s_we_o   = w_req.we;
    assign s_sel_o  = w_req.sel;
    assign s_cyc_o  = w_req.cyc;
    // The timed-out strobe is withdrawn so the slave never sees it complete.
    assign s_stb_o  = w_req.stb & ~w_to;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = s_ack_i & w_gnt0;
    assign m1_ack_o = s_ack_i & w_gnt1;
    assign m0_err_o = (s_err_i | w_to) & w_gnt0;
    assign m1_err_o = (s_err_i | w_to) & w_gnt1;
    assign m0_rty_o = s_rty_i & w_gnt0;
    assign m1_rty_o = s_rty_i & w_gnt1;

    assign gnt_o    = r_state;

endmodule

// File: tb/tb_wbs_arb2.sv
// Bench for wbs_arb2: two master drivers, a registered-ack memory model and a
// scoreboard monitor for grants and per-master responses.
module tb_wbs_arb2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] m0_adr = '0, m0_dat = '0, m1_adr = '0, m1_dat = '0;
    logic        m0_we = 1'b0, m0_cyc = 1'b0, m0_stb = 1'b0;
    logic        m1_we = 1'b0, m1_cyc = 1'b0, m1_stb = 1'b0;
    logic [3:0]  m0_sel = '0, m1_sel = '0;
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic [3:0]  s_sel_o;
    logic [1:0]  gnt_o;
    logic [31:0] slv_rd = '0;
    logic        slv_ack = 1'b0;
    logic        slv_mute = 1'b0;
    logic        s_err_i = 1'b0, s_rty_i = 1'b0;
    logic [31:0] mem [0:255];

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
    } exp_t;

    exp_t       q0[$], q1[$];
    logic [1:0] qg[$];
    logic [1:0] gprev = 2'b00;

    always #5 clk = ~clk;

    wbs_arb2 #(.TO_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we),
        .m0_sel_i(m0_sel), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we),
        .m1_sel_i(m1_sel), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(slv_rd), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_ack_i(slv_ack), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .gnt_o(gnt_o)
    );

    // Memory slave with a registered one-cycle ack; it has no reset of its own.
    always @(posedge clk) begin
        if (s_cyc_o && s_stb_o && !slv_ack && !slv_mute) begin
            slv_ack <= 1'b1;
            if (s_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (s_sel_o[b]) mem[s_adr_o[9:2]][b*8 +: 8] <= s_dat_o[b*8 +: 8];
            end else begin
                slv_rd <= mem[s_adr_o[9:2]];
            end
        end else begin
            slv_ack <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_ack_o) begin
                if (q0.size() == 0) chk("m0 unexpected ack", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = q0.pop_front();
                    chk("m0 ack adr", s_adr_o, e.adr);
                    if (!e.we) chk("m0 rdata", m0_dat_o, e.dat);
                    chk("m1 ack during m0 ack", {31'd0, m1_ack_o}, 32'd0);
                end
            end
            if (m1_ack_o) begin
                if (q1.size() == 0) chk("m1 unexpected ack", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("m1 ack adr", s_adr_o, e.adr);
                    if (!e.we) chk("m1 rdata", m1_dat_o, e.dat);
                    chk("m0 ack during m1 ack", {31'd0, m0_ack_o}, 32'd0);
                end
            end
            if (gnt_o != gprev && gnt_o != 2'b00) begin
                if (qg.size() == 0) chk("unexpected grant", {30'd0, gnt_o}, 32'd0);
                else chk("grant order", {30'd0, gnt_o}, {30'd0, qg.pop_front()});
            end
        end
        gprev <= gnt_o;
    end

    // One single-access transfer; keep=1 holds cyc for the next access of a burst.
    task automatic m_acc(input int m, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic keep);
        exp_t e;
        bit   done;
        e.adr = adr; e.we = we; e.dat = dat;
        done = 1'b0;
        if (m == 0) begin
            q0.push_back(e);
            m0_adr = adr; m0_we = we; m0_dat = we ? dat : 32'h0; m0_sel = 4'hF;
            m0_cyc = 1'b1; m0_stb = 1'b1;
        end else begin
            q1.push_back(e);
            m1_adr = adr; m1_we = we; m1_dat = we ? dat : 32'h0; m1_sel = 4'hF;
            m1_cyc = 1'b1; m1_stb = 1'b1;
        end
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = (m == 0) ? (m0_ack_o | m0_err_o) : (m1_ack_o | m1_err_o);
        end
        if (!done) chk($sformatf("m%0d response timeout", m), 32'd0, 32'd1);
        @(posedge clk); #1;
        if (m == 0) begin
            m0_stb = 1'b0;
            if (!keep) m0_cyc = 1'b0;
        end else begin
            m1_stb = 1'b0;
            if (!keep) m1_cyc = 1'b0;
        end
        if (!keep) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, a1, bad;
        bit m0_done;

        // Reset values
        repeat (2) @(posedge clk); #1;
        chk("reset gnt_o", {30'd0, gnt_o}, 32'd0);
        chk("reset s_cyc/s_stb", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
        chk("reset m acks/errs/rtys",
            {26'd0, m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // m0 single write, then readback
        a0 = 0; a1 = 0;
        qg.push_back(2'b01);
        fork
            m_acc(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (k == 0) chk("gnt before grant edge", {30'd0, gnt_o}, 32'd0);
                if (k == 1) begin
                    chk("gnt one cycle later", {30'd0, gnt_o}, 32'd1);
                    chk("s_adr_o mux", s_adr_o, 32'h0000_0010);
                    chk("s_dat_o mux", s_dat_o, 32'hDEAD_BEEF);
                    chk("s_we/sel/cyc mux", {26'd0, s_we_o, s_sel_o, s_cyc_o}, 32'h3F);
                end
                if (k == 2) chk("ack latency 2", {31'd0, m0_ack_o}, 32'd1);
                a0 += int'(m0_ack_o);
                a1 += int'(m1_ack_o);
            end
        join
        chk("m0 ack pulse count", a0, 32'd1);
        chk("m1 ack stays 0", a1, 32'd0);
        qg.push_back(2'b01);
        m_acc(0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);

        // Simultaneous request after reset: m0 first, then m1 with no idle gap
        do_reset();
        qg.push_back(2'b01);
        qg.push_back(2'b10);
        fork
            m_acc(0, 1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0);
            m_acc(1, 1'b1, 32'h0000_0024, 32'h2222_2222, 1'b0);
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (!m0_cyc) break;
                end
                @(negedge clk);
                chk("handover without bubble", {30'd0, gnt_o}, 32'd2);
            end
        join

        // m0 locked 3-read burst while m1 waits
        m0_done = 1'b0;
        bad = 0;
        qg.push_back(2'b01);
        qg.push_back(2'b10);
        fork
            begin
                m_acc(0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
                m_acc(0, 1'b0, 32'h0000_0020, 32'h1111_1111, 1'b1);
                m_acc(0, 1'b0, 32'h0000_0024, 32'h2222_2222, 1'b0);
                m0_done = 1'b1;
            end
            begin
                repeat (3) @(posedge clk); #1;
                m_acc(1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
            end
            begin
                @(negedge clk);
                for (int i = 0; i < 200 && !m0_done; i++) begin
                    @(negedge clk);
                    if (!m0_done && gnt_o != 2'b01) bad++;
                end
            end
        join
        chk("grant held across burst", bad, 32'd0);

        // Continuous contention: alternating grants
        repeat (3) begin
            qg.push_back(2'b01);
            qg.push_back(2'b10);
        end
        fork
            begin
                m_acc(0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
                m_acc(0, 1'b0, 32'h0000_0020, 32'h1111_1111, 1'b0);
                m_acc(0, 1'b0, 32'h0000_0024, 32'h2222_2222, 1'b0);
            end
            begin
                m_acc(1, 1'b1, 32'h0000_0080, 32'hA0A0_0001, 1'b0);
                m_acc(1, 1'b1, 32'h0000_0084, 32'hA0A0_0002, 1'b0);
                m_acc(1, 1'b0, 32'h0000_0080, 32'hA0A0_0001, 1'b0);
            end
        join
        chk("grant queue drained", qg.size(), 32'd0);

        // Async reset while the slave ack is in flight
        qg.push_back(2'b01);
        m0_adr = 32'h0000_0010; m0_we = 1'b0; m0_sel = 4'hF; m0_cyc = 1'b1; m0_stb = 1'b1;
        a0 = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (slv_ack) begin a0 = 1; break; end
        end
        chk("ack seen before reset", a0, 32'd1);
        chk("s_stb_o high mid-transfer", {31'd0, s_stb_o}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset s_cyc/s_stb", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
        chk("async reset gnt_o", {30'd0, gnt_o}, 32'd0);
        chk("late ack reaches no master", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Stalled slave: watchdog error on the 16th stalled cycle, or stall forever
        slv_mute = 1'b1;
        bad = 0;
        qg.push_back(2'b10);
        m1_adr = 32'h0000_0010; m1_we = 1'b0; m1_sel = 4'hF; m1_cyc = 1'b1; m1_stb = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (m0_err_o || m1_ack_o || m0_ack_o) bad++;
`ifdef WBS_ARB_TIMEOUT_EN
            if (k == 16) begin
                chk("wdt m1_err on 16th stall", {31'd0, m1_err_o}, 32'd1);
                chk("wdt forces s_stb_o low", {31'd0, s_stb_o}, 32'd0);
            end else if (m1_err_o) bad++;
`else
            if (m1_err_o) bad++;
`endif
        end
        chk("no stray err/ack while stalled", bad, 32'd0);
`ifndef WBS_ARB_TIMEOUT_EN
        chk("stalled request still pending", {29'd0, gnt_o, s_stb_o}, 32'h5);
`endif
        @(posedge clk); #1;
        m1_cyc = 1'b0; m1_stb = 1'b0;
        slv_mute = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("idle after stall release", {30'd0, gnt_o}, 32'd0);
        chk("scoreboard queues drained", q0.size() + q1.size() + qg.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
